// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit ALU.
// One operation in flight; operands and results are registered.

// Combinational 32-bit ALU (AND/OR/ADD/SUB/SLT/NOR).
module ALU32Bit (
  input  logic [3:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUResult,
  output logic        Zero
);
  // Opcode decode; unknown codes yield 0.
  always_comb begin
    ALUResult = 32'd0;
    case (ALUControl)
      4'b0000: ALUResult = A & B;
      4'b0001: ALUResult = A | B;
      4'b0010: ALUResult = A + B;
      4'b0110: ALUResult = A - B;
      4'b0111: ALUResult = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      4'b1100: ALUResult = ~(A | B);
      default: ALUResult = 32'd0;
    endcase
  end

  assign Zero = (ALUResult == 32'd0);
endmodule

module alu_share_arbiter #(
  parameter logic INIT_LAST = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  ReqValid,
  output logic [1:0]  ReqReady,
  input  logic [7:0]  ReqOp,
  input  logic [63:0] ReqA,
  input  logic [63:0] ReqB,
  output logic [1:0]  RspValid,
  input  logic [1:0]  RspReady,
  output logic [31:0] RspResult,
  output logic        RspZero,
  output logic        RspErr,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        lg_q;
  logic        owner_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_q;
  logic        zero_q, err_q;

  logic        gnt_idx;
  logic        accept;
  logic        legal;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;

  // Illegal opcodes never reach the ALU; it sees AND instead and the
  // result is discarded in favour of the error response.
  always_comb begin
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign alu_op = legal ? op_q : 4'b0000;

  ALU32Bit u_alu (
    .ALUControl (alu_op),
    .A          (a_q),
    .B          (b_q),
    .ALUResult  (alu_res),
    .Zero       (alu_zero)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, round-robin grant and handshake outputs.
  always_comb begin
    state_d  = state_q;
    ReqReady = 2'b00;
    RspValid = 2'b00;
    gnt_idx  = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (ReqValid == 2'b11) gnt_idx = ~lg_q;
        else                   gnt_idx = ReqValid[1];
        if ((|ReqValid) && !Rst) begin
          ReqReady[gnt_idx] = 1'b1;
          accept            = 1'b1;
          state_d           = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        RspValid[owner_q] = 1'b1;
        if (RspReady[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lg_q    <= INIT_LAST;
      owner_q <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= gnt_idx;
        lg_q    <= gnt_idx;
        op_q    <= gnt_idx ? ReqOp[7:4]  : ReqOp[3:0];
        a_q     <= gnt_idx ? ReqA[63:32] : ReqA[31:0];
        b_q     <= gnt_idx ? ReqB[63:32] : ReqB[31:0];
      end
      if (state_q == EXEC) begin
        res_q  <= legal ? alu_res : 32'd0;
        zero_q <= legal & alu_zero;
        err_q  <= ~legal;
      end
    end
  end

  assign RspResult = res_q;
  assign RspZero   = zero_q;
  assign RspErr    = err_q;
  assign Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected responses are queued on
// accept and compared on each response handshake.
module tb_alu_share_arbiter;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  ReqValid = 2'b00;
  logic [1:0]  ReqReady;
  logic [7:0]  ReqOp = 8'd0;
  logic [63:0] ReqA = 64'd0;
  logic [63:0] ReqB = 64'd0;
  logic [1:0]  RspValid;
  logic [1:0]  RspReady = 2'b11;
  logic [31:0] RspResult;
  logic        RspZero, RspErr, Busy;

  alu_share_arbiter #(.INIT_LAST(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .RspValid(RspValid),
    .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
    .RspErr(RspErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]  vld;
    logic        err;
    logic        zero;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  logic grants[$];
  int   n_cmp = 0, n_err = 0;
  int   n_acc = 0, n_rsp = 0;
  int   cyc = 0, acc_cyc = 0, hs_cyc = 0;
  logic lat_done = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic idx, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.vld = idx ? 2'b10 : 2'b01;
    e.err = 1'b0;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR: e.res = ~(a | b);
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.res == 32'd0);
    return e;
  endfunction

  always @(posedge Clk) cyc++;

  // Monitor: record accepts into the scoreboard, check responses on handshake.
  always @(negedge Clk) begin
    if (!Rst) begin
      logic [1:0] acc;
      logic       idx;
      acc = ReqValid & ReqReady;
      if (acc != 2'b00) begin
        idx = acc[1];
        sb.push_back(model(idx, idx ? ReqOp[7:4] : ReqOp[3:0],
                           idx ? ReqA[63:32] : ReqA[31:0],
                           idx ? ReqB[63:32] : ReqB[31:0]));
        grants.push_back(idx);
        n_acc++;
        acc_cyc  = cyc;
        lat_done = 1'b0;
      end
      if (RspValid != 2'b00) begin
        chk("rsp_onehot", {31'd0, $onehot(RspValid)}, 32'd1);
        if (!lat_done) begin
          chk("latency", cyc - acc_cyc, 32'd2);
          lat_done = 1'b1;
        end
        if ((RspValid & RspReady) != 2'b00) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", {30'd0, RspValid}, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_owner", {30'd0, RspValid}, {30'd0, e.vld});
            chk("rsp_result", RspResult, e.res);
            chk("rsp_zero", {31'd0, RspZero}, {31'd0, e.zero});
            chk("rsp_err", {31'd0, RspErr}, {31'd0, e.err});
          end
          n_rsp++;
          hs_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    for (int k = 0; k < 100; k++) begin
      @(posedge Clk); #1;
      if (n_acc >= target) break;
    end
    if (n_acc < target) chk("acc_timeout", n_acc, target);
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 100; k++) begin
      @(posedge Clk); #1;
      if (n_rsp >= target) break;
    end
    if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin ReqOp[3:0] = op; ReqA[31:0]  = a; ReqB[31:0]  = b; end
    else        begin ReqOp[7:4] = op; ReqA[63:32] = a; ReqB[63:32] = b; end
  endtask

  // Present one op, wait for accept, drop valid, wait for its response.
  task automatic run_op(input int i, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int r0;
    r0 = n_rsp;
    set_req(i, op, a, b);
    ReqValid[i] = 1'b1;
    wait_acc(n_acc + 1);
    ReqValid[i] = 1'b0;
    set_req(i, 4'b1111, $urandom, $urandom);
    wait_rsp(r0 + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {30'd0, ReqReady}, 32'd0);
    chk({tag, "_valid"}, {30'd0, RspValid}, 32'd0);
    chk({tag, "_result"}, RspResult, 32'd0);
    chk({tag, "_zero"}, {31'd0, RspZero}, 32'd0);
    chk({tag, "_err"}, {31'd0, RspErr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int base, r0;
    ReqValid = 2'b11;
    #12;
    check_reset_outputs("rst");
    ReqValid = 2'b00;
    @(posedge Clk); #1 Rst = 1'b0;

    // Both requesters valid continuously: grants alternate starting at 0.
    grants.delete();
    set_req(0, OP_SUB, 32'd5, 32'd5);
    set_req(1, OP_SUB, 32'd5, 32'd5);
    r0 = n_rsp;
    ReqValid = 2'b11;
    wait_acc(4);
    ReqValid = 2'b00;
    wait_rsp(r0 + 4);
    for (int k = 0; k < 4; k++)
      if (k < grants.size()) chk($sformatf("grant%0d", k), {31'd0, grants[k]}, k % 2);
    chk("grant_count", grants.size(), 32'd4);

    // ADD overflow wraps, no flag.
    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_res", RspResult, 32'h8000_0000);

    // Signed SLT on requester 1.
    run_op(1, OP_SLT, 32'hFFFF_FFFF, 32'd0);
    run_op(1, OP_SLT, 32'd0, 32'hFFFF_FFFF);

    // Illegal opcode then NOR.
    run_op(0, 4'b0011, 32'd9, 32'd9);
    run_op(0, OP_NOR, 32'd0, 32'd0);
    run_op(1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(0, OP_OR, 32'h0000_00F0, 32'h0000_000F);

    // Back-pressure on owner 0 while requester 1 waits; RspReady1 is ignored.
    RspReady = 2'b10;
    set_req(0, OP_ADD, 32'd1, 32'd2);
    ReqValid[0] = 1'b1;
    wait_acc(n_acc + 1);
    ReqValid[0] = 1'b0;
    set_req(0, OP_SUB, $urandom, $urandom);
    set_req(1, OP_OR, 32'hF0, 32'h0F);
    ReqValid[1] = 1'b1;
    @(posedge Clk); #1;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", {30'd0, RspValid}, 32'd1);
      chk("hold_result", RspResult, 32'd3);
      chk("hold_ready", {30'd0, ReqReady}, 32'd0);
      chk("hold_busy", {31'd0, Busy}, 32'd1);
      ReqA[31:0] = $urandom;
      @(posedge Clk); #1;
    end
    base = n_acc;
    r0 = n_rsp;
    RspReady = 2'b11;
    wait_acc(base + 1);
    chk("acc_after_hs", acc_cyc - hs_cyc, 32'd1);
    ReqValid[1] = 1'b0;
    wait_rsp(r0 + 2);

    // Reset during EXEC drops the op.
    set_req(1, OP_ADD, 32'd100, 32'd200);
    ReqValid[1] = 1'b1;
    wait_acc(n_acc + 1);
    ReqValid[1] = 1'b0;
    Rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    lat_done = 1'b1;
    @(posedge Clk); @(posedge Clk); #1 Rst = 1'b0;
    r0 = n_rsp;
    repeat (6) @(posedge Clk);
    #1;
    chk("no_rsp_after_rst", n_rsp, r0);
    chk("idle_after_rst", {31'd0, Busy}, 32'd0);
    run_op(1, OP_ADD, 32'd100, 32'd200);
    chk("post_rst_res", RspResult, 32'd300);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
